// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that lets NREQ requesters share one UART transmitter.
// Each grant sends a 5-byte frame: header (HDR | index) then the latched 32-bit word MSB first.
module uart_tx_scheduler #(
    parameter int         NREQ = 4,
    parameter logic [7:0] HDR  = 8'hA0
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic [NREQ-1:0]        req_i,
    input  logic [32*NREQ-1:0]     req_data_i,
    input  logic                   tx_busy_i,
    output logic [NREQ-1:0]        grant_o,
    output logic [NREQ-1:0]        done_o,
    output logic                   wr_en_o,
    output logic [7:0]             txdata_o,
    output logic                   busy_o
);

    localparam int         IW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW:0] NREQ_C = (IW+1)'(NREQ);

    typedef enum logic [2:0] {
        IDLE, ARB, LOAD, STROBE, WAIT_HI, WAIT_LO, NEXT, FINISH
    } state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic              busy_q, busy_d;
    logic [31:0]       word_q, word_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [7:0]        txdata_q, txdata_d;
    logic              wr_en_q, wr_en_d;
    logic              tx_busy_q;

    logic [31:0]       words [NREQ];
    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   rot;
    logic [NREQ-1:0]   lowest;
    logic [IW-1:0]     win_off;
    logic [IW:0]       idx_sum;
    logic [IW-1:0]     win_idx;
    logic [NREQ-1:0]   win_oh;
    logic              win_found;
    logic [7:0]        next_byte;

    // Rotate requests so bit k is requester (ptr+k) mod NREQ; the lowest set bit wins.
    assign req_dbl   = {req_i, req_i} >> ptr_q;
    assign rot       = req_dbl[NREQ-1:0];
    assign lowest    = rot & (~rot + NREQ'(1));
    assign win_found = |req_i;
    assign idx_sum   = {1'b0, ptr_q} + {1'b0, win_off};
    assign win_idx   = (idx_sum >= NREQ_C) ? IW'(idx_sum - NREQ_C) : IW'(idx_sum);

    generate
        for (genvar gi = 0; gi < IW; gi++) begin : g_enc
            logic [NREQ-1:0] sel_mask;
            for (genvar gj = 0; gj < NREQ; gj++) begin : g_bit
                assign sel_mask[gj] = (((gj >> gi) & 1) == 1);
            end
            assign win_off[gi] = |(lowest & sel_mask);
        end

        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign words[gi]  = req_data_i[32*gi +: 32];
            assign win_oh[gi] = (win_idx == IW'(gi));
            assign done_o[gi] = (state_q == FINISH) && (idx_q == IW'(gi));
        end
    endgenerate

    // Byte strobed after the current one; cnt_q counts bytes already sent minus one.
    always_comb begin
        next_byte = 8'h00;
        case (cnt_q)
            3'd0:    next_byte = word_q[31:24];
            3'd1:    next_byte = word_q[23:16];
            3'd2:    next_byte = word_q[15:8];
            default: next_byte = word_q[7:0];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        grant_d  = grant_q;
        busy_d   = busy_q;
        word_d   = word_q;
        cnt_d    = cnt_q;
        txdata_d = txdata_q;
        wr_en_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (win_found) begin
                    grant_d = win_oh;
                    busy_d  = 1'b1;
                    idx_d   = win_idx;
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                word_d   = words[idx_q];
                cnt_d    = 3'd0;
                txdata_d = HDR | 8'(idx_q);
                state_d  = STROBE;
            end
            STROBE: begin
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy_i) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (tx_busy_q && !tx_busy_i) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (cnt_q == 3'd4) begin
                    state_d = FINISH;
                end else begin
                    cnt_d    = cnt_q + 3'd1;
                    txdata_d = next_byte;
                    state_d  = STROBE;
                end
            end
            FINISH: begin
                grant_d  = '0;
                busy_d   = 1'b0;
                txdata_d = 8'h00;
                ptr_d    = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        wr_en_d = (state_d == STROBE);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            word_q    <= '0;
            cnt_q     <= 3'd0;
            txdata_q  <= 8'h00;
            wr_en_q   <= 1'b0;
            tx_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            word_q    <= word_d;
            cnt_q     <= cnt_d;
            txdata_q  <= txdata_d;
            wr_en_q   <= wr_en_d;
            tx_busy_q <= tx_busy_i;
        end
    end

    assign grant_o  = grant_q;
    assign busy_o   = busy_q;
    assign wr_en_o  = wr_en_q;
    assign txdata_o = txdata_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed vector table, corner sequences,
// then randomized frames checked against a round-robin reference model.
module tb_uart_tx_scheduler;

    localparam int         NREQ = 4;
    localparam logic [7:0] HDR  = 8'hA0;

    logic                clk = 1'b0;
    logic                reset_ni;
    logic [NREQ-1:0]     req_i;
    logic [32*NREQ-1:0]  req_data_i;
    logic                tx_busy_i;
    logic [NREQ-1:0]     grant_o;
    logic [NREQ-1:0]     done_o;
    logic                wr_en_o;
    logic [7:0]          txdata_o;
    logic                busy_o;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.NREQ(NREQ), .HDR(HDR)) dut (
        .clk_i      (clk),
        .reset_ni   (reset_ni),
        .req_i      (req_i),
        .req_data_i (req_data_i),
        .tx_busy_i  (tx_busy_i),
        .grant_o    (grant_o),
        .done_o     (done_o),
        .wr_en_o    (wr_en_o),
        .txdata_o   (txdata_o),
        .busy_o     (busy_o)
    );

    int checks = 0;
    int errors = 0;

    // UART model: busy for busy_fixed cycles per byte, or a random 1..8 when busy_fixed is 0.
    int uart_cnt   = 0;
    int busy_fixed = 10;
    always @(posedge clk) begin
        if (uart_cnt > 0)
            uart_cnt <= uart_cnt - 1;
        else if (wr_en_o)
            uart_cnt <= (busy_fixed > 0) ? busy_fixed : int'($urandom_range(1, 8));
    end
    assign tx_busy_i = (uart_cnt != 0);

    logic [7:0] byte_q[$];
    int         done_cnt = 0;

    always @(negedge clk) begin
        if (wr_en_o) begin
            byte_q.push_back(txdata_o);
            checks++;
            if (tx_busy_i || $countones(grant_o) != 1) begin
                errors++;
                $display("FAIL wr_en_protocol: tx_busy=%0b grant=%b, required tx_busy=0 and one-hot grant",
                         tx_busy_i, grant_o);
            end
        end
        if (done_o != '0) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the next winner is the first requester after the last one served.
    int last_served = NREQ - 1;
    function automatic int model_winner(input logic [NREQ-1:0] mask);
        for (int k = 1; k <= NREQ; k++)
            if (mask[(last_served + k) % NREQ]) return (last_served + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [32*NREQ-1:0] mk_data(input logic [31:0] w, input int exp);
        logic [32*NREQ-1:0] d;
        d = '0;
        for (int i = 0; i < NREQ; i++)
            d[32*i +: 32] = (i == exp) ? w : (w ^ 32'hA5A5_0000 ^ 32'(i + 1));
        return d;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_ni = 1'b0;
        req_i    = '0;
        @(negedge clk);
        check("rst grant",  32'(grant_o),  32'h0);
        check("rst done",   32'(done_o),   32'h0);
        check("rst wr_en",  32'(wr_en_o),  32'h0);
        check("rst txdata", 32'(txdata_o), 32'h0);
        check("rst busy",   32'(busy_o),   32'h0);
        reset_ni    = 1'b1;
        last_served = NREQ - 1;
        byte_q.delete();
    endtask

    task automatic run_frame(input string tag, input logic [NREQ-1:0] mask,
                             input logic [32*NREQ-1:0] data, input logic [32*NREQ-1:0] new_data,
                             input bit change, input bit drop, input int exp_idx);
        int          cyc;
        logic [31:0] w;
        logic [7:0]  exp_b [5];
        @(negedge clk);
        req_i      = mask;
        req_data_i = data;
        w = data[32*exp_idx +: 32];
        exp_b[0] = HDR | 8'(exp_idx);
        exp_b[1] = w[31:24];
        exp_b[2] = w[23:16];
        exp_b[3] = w[15:8];
        exp_b[4] = w[7:0];
        cyc = 0;
        while (grant_o == '0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " grant"}, 32'(grant_o), 32'(1) << exp_idx);
        check({tag, " busy"},  32'(busy_o),  32'h1);
        @(posedge clk);
        #1;
        if (change) req_data_i = new_data;
        cyc = 0;
        while (done_o == '0 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (drop && byte_q.size() >= 2) req_i[exp_idx] = 1'b0;
        end
        check({tag, " done"},   32'(done_o),        32'(1) << exp_idx);
        check({tag, " nbytes"}, 32'(byte_q.size()), 32'd5);
        for (int b = 0; b < 5 && b < byte_q.size(); b++)
            check($sformatf("%s byte%0d", tag, b), 32'(byte_q[b]), 32'(exp_b[b]));
        $display("frame %s: grant=%0d header=%02h word=%08h bytes=%0d", tag, exp_idx, exp_b[0], w, byte_q.size());
        byte_q.delete();
        @(negedge clk);
        check({tag, " grant_after"}, 32'(grant_o), 32'h0);
        check({tag, " busy_after"},  32'(busy_o),  32'h0);
        check({tag, " done_pulse"},  32'(done_o),  32'h0);
        last_served = exp_idx;
    endtask

    typedef struct {
        bit              rst;
        logic [NREQ-1:0] mask;
        logic [31:0]     word;
        logic [31:0]     new_word;
        bit              change;
        bit              drop;
        int              exp_idx;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int cyc;
        int nbytes;
        int done_before;
        logic [NREQ-1:0]    mask;
        logic [32*NREQ-1:0] data;
        logic [32*NREQ-1:0] ndata;
        int                 exp;

        vecs[0]  = '{1'b1, 4'b0100, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 2};
        vecs[1]  = '{1'b1, 4'b1111, 32'h01020304, 32'h0,        1'b0, 1'b0, 0};
        vecs[2]  = '{1'b0, 4'b1111, 32'h10203040, 32'h0,        1'b0, 1'b0, 1};
        vecs[3]  = '{1'b0, 4'b1111, 32'hC0FFEE00, 32'h0,        1'b0, 1'b0, 2};
        vecs[4]  = '{1'b0, 4'b1111, 32'h87654321, 32'h0,        1'b0, 1'b0, 3};
        vecs[5]  = '{1'b0, 4'b1111, 32'h0BADF00D, 32'h0,        1'b0, 1'b0, 0};
        vecs[6]  = '{1'b0, 4'b1111, 32'h13579BDF, 32'h0,        1'b0, 1'b0, 1};
        vecs[7]  = '{1'b0, 4'b1111, 32'h2468ACE0, 32'h0,        1'b0, 1'b0, 2};
        vecs[8]  = '{1'b0, 4'b1111, 32'hFEDCBA98, 32'h0,        1'b0, 1'b0, 3};
        vecs[9]  = '{1'b0, 4'b0110, 32'h600DCAFE, 32'h0,        1'b0, 1'b0, 1};
        vecs[10] = '{1'b0, 4'b0110, 32'hFACEB00C, 32'h0,        1'b0, 1'b0, 2};
        vecs[11] = '{1'b0, 4'b0010, 32'hA1B2C3D4, 32'h0,        1'b0, 1'b1, 1};
        vecs[12] = '{1'b0, 4'b0001, 32'h11223344, 32'h55667788, 1'b1, 1'b0, 0};

        reset_ni   = 1'b0;
        req_i      = '0;
        req_data_i = '0;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 13; v++) begin
            if (vecs[v].rst) do_reset();
            run_frame($sformatf("vec%0d", v), vecs[v].mask,
                      mk_data(vecs[v].word, vecs[v].exp_idx),
                      mk_data(vecs[v].new_word, vecs[v].exp_idx),
                      vecs[v].change, vecs[v].drop, vecs[v].exp_idx);
        end

        // Request withdrawn while the arbiter is deciding: nothing is granted.
        do_reset();
        @(negedge clk);
        req_i = 4'b0100;
        @(posedge clk);
        #1;
        req_i = '0;
        repeat (4) begin
            @(negedge clk);
            check("arb_drop grant", 32'(grant_o), 32'h0);
        end
        check("arb_drop bytes", 32'(byte_q.size()), 32'h0);
        run_frame("arb_drop_next", 4'b1001, mk_data(32'h0A0B0C0D, 0), '0, 1'b0, 1'b0, 0);

        // Reset during the third byte aborts the frame.
        @(negedge clk);
        req_i      = 4'b0010;
        req_data_i = mk_data(32'h31415926, 1);
        cyc = 0;
        while (byte_q.size() < 3 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("midrst reached_byte3", 32'(byte_q.size() >= 3), 32'h1);
        reset_ni = 1'b0;
        req_i    = '0;
        @(posedge clk);
        #1;
        check("midrst grant", 32'(grant_o), 32'h0);
        check("midrst wr_en", 32'(wr_en_o), 32'h0);
        check("midrst busy",  32'(busy_o),  32'h0);
        check("midrst done",  32'(done_o),  32'h0);
        done_before = done_cnt;
        nbytes      = byte_q.size();
        reset_ni    = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst no_more_bytes", 32'(byte_q.size()), 32'(nbytes));
        check("midrst no_done",       32'(done_cnt),      32'(done_before));
        $display("midrst: aborted after %0d bytes", nbytes);
        byte_q.delete();
        last_served = NREQ - 1;
        run_frame("after_rst", 4'b1000, mk_data(32'h27182818, 3), '0, 1'b0, 1'b0, 3);

        // Randomized frames against the round-robin model.
        busy_fixed = 0;
        for (int r = 0; r < 40; r++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                data[32*i +: 32]  = $urandom;
                ndata[32*i +: 32] = $urandom;
            end
            exp = model_winner(mask);
            run_frame($sformatf("rnd%0d", r), mask, data, ndata,
                      bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the UART transmitter (2..8).
REQ-002 Parameter HDR, default 8'hA0, frame header base; header byte = HDR | requester index.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 req  input  NREQ  per-requester send request, level, held until matching done.
REQ-006 req_data  input  32*NREQ  packed words; requester i occupies bits [32*i+31:32*i].
REQ-007 tx_busy  input  1  UART transmitter busy flag.
REQ-008 grant  output  NREQ  one-hot owner of the transmitter; all-zero when idle.
REQ-009 done  output  NREQ  one-cycle pulse on bit i when requester i's frame is fully sent.
REQ-010 wr_en  output  1  one-cycle strobe loading txdata into the UART.
REQ-011 txdata  output  8  byte presented to the UART, valid while wr_en=1.
REQ-012 busy  output  1  high from grant until the cycle after done.

Function
REQ-013 Frame = 5 bytes: header (HDR | index), then the latched word MSB first (bits 31:24, 23:16, 15:8, 7:0).
REQ-014 States: IDLE, ARB, LOAD, STROBE, WAIT_HI, WAIT_LO, NEXT, FINISH.
REQ-015 IDLE: any req bit set -> ARB next cycle; otherwise stay.
REQ-016 ARB: round-robin search starting at pointer ptr, wrapping NREQ-1 -> 0; first set req bit wins; grant asserted one-hot; go LOAD.
REQ-017 ARB with req all-zero (request dropped): return to IDLE, grant stays zero, ptr unchanged.
REQ-018 LOAD: latch the winner's 32-bit word and index; byte counter = 0; go STROBE.
REQ-019 Changes to req_data after LOAD do not affect the frame in progress.
REQ-020 STROBE: wr_en=1 for exactly one cycle with txdata = current byte; go WAIT_HI.
REQ-021 WAIT_HI: wait for tx_busy=1; go WAIT_LO.
REQ-022 WAIT_LO: on falling edge of tx_busy (registered previous value 1, current 0) go NEXT; edge detection is internal.
REQ-023 NEXT: byte counter = 4 -> FINISH; else increment counter, go STROBE.
REQ-024 FINISH: done[index]=1 for one cycle, grant cleared, ptr = (index+1) mod NREQ; go IDLE.
REQ-025 Requester deasserting req after grant does not abort; the frame completes and done still pulses.
REQ-026 A requester holding req after its done is re-eligible but ranks behind every other pending requester.
REQ-027 Minimum spacing between frames: FINISH -> IDLE -> ARB; no grant overlap ever.
REQ-028 txdata holds the last strobed byte between strobes; it is 8'h00 outside a frame.
REQ-029 At most one wr_en per byte; exactly 5 wr_en pulses per frame.

Reset
REQ-030 reset=0 sampled at a rising edge -> state IDLE, ptr=0, grant=0, done=0, wr_en=0, txdata=8'h00, busy=0, byte counter=0, tx_busy history=0.
REQ-031 Reset mid-frame aborts immediately: no done pulse, no further wr_en; the UART may finish its current byte untouched.
REQ-032 First arbitration after reset starts at requester 0.

Verification
REQ-033 Single request: req=4'b0100, word 32'hDEADBEEF, UART model busy 10 cycles/byte -> grant=4'b0100, txdata sequence A2,DE,AD,BE,EF, one done[2] pulse, then grant=0.
REQ-034 Round-robin: req=4'b1111 held -> grants in order 0,1,2,3,0; headers A0,A1,A2,A3,A0.
REQ-035 Wrap and skip: after serving 3, req=4'b0110 -> next grant requester 1, then 2.
REQ-036 Request drop: requester 1 granted, req[1] cleared after byte 2 -> all 5 bytes still sent, done[1] pulses once.
REQ-037 Data stability: req_data[0] changed from 32'h11223344 to 32'h55667788 mid-frame -> bytes sent A0,11,22,33,44.
REQ-038 Reset mid-frame: reset=0 during byte 3 -> next cycle grant=0, wr_en=0, busy=0, no done; next request from 4'b1000 gets header A3.
